// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle on operand magnitudes, sign-corrected on completion.
// Divide-by-zero and signed overflow skip the iteration and finish in one cycle.
// flush aborts any op in flight. done/rd_complete pulse for one cycle with the result.
module div_unit #(
  parameter int DATA_SIZE = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [DATA_SIZE-1:0] rs1_data,
  input  logic [DATA_SIZE-1:0] rs2_data,
  input  logic                 flush,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_complete,
  output logic [DATA_SIZE-1:0] result
);

  localparam int W  = DATA_SIZE;
  localparam int CW = $clog2(DATA_SIZE) + 1;

  localparam logic [W-1:0] MIN_VAL  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
  localparam logic [W-1:0] ZERO     = {W{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] counter_reg;
  logic [W-1:0]  quo_reg;      // dividend magnitude shifting out, quotient bits shifting in
  logic [W-1:0]  div_reg;      // divisor magnitude
  logic [W:0]    rem_reg;      // partial remainder, one extra bit for the subtract borrow
  logic          neg_q_reg;
  logic          neg_r_reg;
  logic          is_rem_reg;
  logic [W-1:0]  result_reg;

  // Operand decode at capture time
  logic          op_signed;
  logic          a_neg;
  logic          b_neg;
  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;
  logic          div_zero;
  logic          overflow;
  logic [W-1:0]  fast_result;

  // One restoring step and its sign-corrected final values
  logic [W:0]    rem_shift;
  logic [W:0]    diff;
  logic          step_ok;
  logic [W:0]    rem_step;
  logic [W-1:0]  quo_step;
  logic [W-1:0]  q_final;
  logic [W-1:0]  r_final;

  // Classify the incoming operands and precompute the special-case result
  always_comb begin
    op_signed = ~op[0];
    a_neg     = op_signed & rs1_data[W-1];
    b_neg     = op_signed & rs2_data[W-1];
    a_mag     = a_neg ? (ZERO - rs1_data) : rs1_data;
    b_mag     = b_neg ? (ZERO - rs2_data) : rs2_data;
    div_zero  = (rs2_data == ZERO);
    overflow  = op_signed && (rs1_data == MIN_VAL) && (rs2_data == ALL_ONES);
    if (div_zero) begin
      fast_result = op[1] ? rs1_data : ALL_ONES;
    end else begin
      fast_result = op[1] ? ZERO : MIN_VAL;
    end
  end

  // Shift-subtract step: bring in the next dividend bit, keep the difference if no borrow
  always_comb begin
    rem_shift = {rem_reg[W-1:0], quo_reg[W-1]};
    diff      = rem_shift - {1'b0, div_reg};
    step_ok   = ~diff[W];
    rem_step  = step_ok ? diff : rem_shift;
    quo_step  = {quo_reg[W-2:0], step_ok};
    q_final   = neg_q_reg ? (ZERO - quo_step) : quo_step;
    r_final   = neg_r_reg ? (ZERO - rem_step[W-1:0]) : rem_step[W-1:0];
  end

  // Control FSM with datapath registers and the held result
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      counter_reg <= '0;
      quo_reg     <= '0;
      div_reg     <= '0;
      rem_reg     <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      is_rem_reg  <= 1'b0;
      result_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // flush beats a same-cycle start: nothing is captured
          if (start && !flush) begin
            is_rem_reg <= op[1];
            neg_q_reg  <= a_neg ^ b_neg;
            neg_r_reg  <= a_neg;
            quo_reg    <= a_mag;
            div_reg    <= b_mag;
            rem_reg    <= '0;
            if (div_zero || overflow) begin
              result_reg  <= fast_result;
              counter_reg <= '0;
              state_reg   <= DONE;
            end else begin
              counter_reg <= CW'(W);
              state_reg   <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            counter_reg <= '0;
            state_reg   <= IDLE;
          end else begin
            quo_reg     <= quo_step;
            rem_reg     <= rem_step;
            counter_reg <= counter_reg - CW'(1);
            // The step that brings the counter to zero is the last one
            if (counter_reg == CW'(1)) begin
              result_reg <= is_rem_reg ? r_final : q_final;
              state_reg  <= DONE;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Status outputs decode the state register; done is masked by a same-cycle flush
  always_comb begin
    busy        = (state_reg == CALC);
    done        = (state_reg == DONE) && !flush;
    rd_complete = done;
    result      = result_reg;
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and random checks of div_unit against an arithmetic reference.
module tb_div_unit;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        busy;
  logic        done;
  logic        rd_complete;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] MINV = 32'h8000_0000;

  div_unit #(.DATA_SIZE(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .op          (op),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .rd_complete (rd_complete),
    .result      (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // RV32M semantics written directly from the arithmetic rules
  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    logic ovf;
    ovf = (a == MINV) && (b == 32'hFFFF_FFFF);
    case (o)
      2'b00:   ref_model = (b == 0) ? 32'hFFFF_FFFF : ovf ? MINV : 32'($signed(a) / $signed(b));
      2'b01:   ref_model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   ref_model = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: ref_model = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    is_fast = (b == 0) || (!o[0] && a == MINV && b == 32'hFFFF_FFFF);
  endfunction

  // Issue one op, measure latency and busy cycles, check result and the single-cycle pulse
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    int cycles;
    int busy_cnt;
    bit got;
    logic [31:0] exp;
    bit fast;
    exp  = ref_model(o, a, b);
    fast = is_fast(o, a, b);
    @(negedge clock);
    op = o; rs1_data = a; rs2_data = b; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    cycles = 1; busy_cnt = 0; got = 0;
    while (!got && cycles < 60) begin
      if (done) begin
        got = 1;
      end else begin
        if (busy) busy_cnt++;
        @(posedge clock);
        #1;
        cycles++;
      end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, cycles, fast ? 32'd1 : 32'd33);
    check({tag, "_busy_cycles"}, busy_cnt, fast ? 32'd0 : 32'd32);
    check({tag, "_result"}, result, exp);
    check({tag, "_rd_complete"}, 32'(rd_complete), 32'd1);
    $display("op=%0d a=%h b=%h result=%h exp=%h latency=%0d", o, a, b, result, exp, cycles);
    @(posedge clock);
    #1;
    check({tag, "_done_pulse_end"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_result_held"}, result, exp);
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  ro;
    int done_hits;
    reset_n = 1'b0; start = 1'b0; op = 2'b00; rs1_data = '0; rs2_data = '0; flush = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    do_op("divu_100_7", 2'b01, 32'd100, 32'd7);
    do_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    do_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2);
    do_op("div_x_0", 2'b00, 32'd1234, 32'd0);
    do_op("remu_5_0", 2'b11, 32'd5, 32'd0);
    do_op("div_ovf", 2'b00, MINV, 32'hFFFF_FFFF);
    do_op("rem_ovf", 2'b10, MINV, 32'hFFFF_FFFF);
    do_op("divu_min_m1", 2'b01, MINV, 32'hFFFF_FFFF);
    do_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE);

    // Flush during CALC aborts with no done and an unchanged result
    held = result;
    @(negedge clock);
    op = 2'b01; rs1_data = 32'd999; rs2_data = 32'd3; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    flush = 1'b1;
    #1;
    check("flush_done_masked", 32'(done), 32'd0);
    @(posedge clock);
    #1 flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    done_hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (done || busy) done_hits++;
    end
    check("flush_no_done", done_hits, 32'd0);
    check("flush_result", result, held);

    // start together with flush in IDLE is dropped
    @(negedge clock);
    op = 2'b00; rs1_data = 32'd50; rs2_data = 32'd0; start = 1'b1; flush = 1'b1;
    @(posedge clock);
    #1 start = 1'b0; flush = 1'b0;
    done_hits = 0;
    for (int i = 0; i < 5; i++) begin
      if (done || busy) done_hits++;
      @(posedge clock);
      #1;
    end
    check("start_flush_no_capture", done_hits, 32'd0);
    check("start_flush_result", result, held);

    // Reset asserted mid-calculation clears everything at once
    do_op("pre_reset", 2'b01, 32'd77, 32'd0);
    @(negedge clock);
    op = 2'b01; rs1_data = 32'd1000; rs2_data = 32'd9; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (5) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_result", result, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    done_hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (done || busy) done_hits++;
    end
    check("rst_release_quiet", done_hits, 32'd0);

    // Random ops, with occasional special operands
    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = MINV; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        4: rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      if (rb == 32'd0 && $urandom_range(0, 1) == 0) rb = 32'd1;
      do_op("rand", ro, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
